display_scan_driver: RTL and testbench

DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

---
 rtl/display_scan_driver.sv | 120 ++++++++++++
 tb/tb_display_scan_driver.sv | 138 +++++++++++++
 2 files changed

// File: rtl/display_scan_driver.sv
// Purpose: drives a multiplexed 7-segment display from a 4-bit count, one digit per scan_in rising edge.
// Latency: scan_tick in cycle N gives all anodes off in N+1 and the next digit in N+2; all outputs registered.
// Backpressure: none; scan ticks arriving outside SHOW are dropped, and enable=0 parks the scan in IDLE.
module display_scan_driver #(
    parameter int NUM_DIGITS    = 4,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [3:0]            value,
    input  logic                  scan_in,
    input  logic                  enable,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic [2:0]            digit_idx
);

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    state_t     state;
    logic       s1, s2, s3;
    logic       scan_tick;
    logic [3:0] shadow;
    logic       wrap;
    logic [2:0] idx_inc;
    logic [3:0] shadow_nxt;

    assign scan_tick  = s2 & ~s3;
    assign wrap       = (digit_idx == 3'(NUM_DIGITS - 1));
    assign idx_inc    = wrap ? 3'd0 : digit_idx + 3'd1;
    // The shadow only follows value at the frame boundary, so one frame never mixes two counts.
    assign shadow_nxt = wrap ? value : shadow;

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] seg_for(input logic [2:0] idx, input logic [3:0] shd);
        logic [3:0] dv;
        logic       blank;
        dv = 4'd0;
        if (idx == 3'd0)
            dv = (shd >= 4'd10) ? shd - 4'd10 : shd;
        else if (idx == 3'd1)
            dv = (shd >= 4'd10) ? 4'd1 : 4'd0;
        blank = BLANK_LEADING && (idx != 3'd0) && (dv == 4'd0);
        return blank ? 7'h7F : enc(dv);
    endfunction

    function automatic logic [NUM_DIGITS-1:0] an_for(input logic [2:0] idx);
        logic [NUM_DIGITS-1:0] a;
        a = '1;
        for (int i = 0; i < NUM_DIGITS; i++)
            a[i] = (idx != 3'(i));
        return a;
    endfunction

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            state     <= IDLE;
            digit_idx <= 3'd0;
            shadow    <= 4'd0;
            an        <= '1;
            seg       <= 7'h7F;
        end else begin
            s1 <= scan_in;
            s2 <= s1;
            s3 <= s2;
            if (!enable) begin
                state <= IDLE;
                an    <= '1;
                seg   <= 7'h7F;
            end else begin
                case (state)
                    IDLE: begin
                        state <= SHOW;
                        an    <= an_for(digit_idx);
                        seg   <= seg_for(digit_idx, shadow);
                    end
                    SHOW: begin
                        if (scan_tick) begin
                            state <= GAP;
                            an    <= '1;
                        end
                    end
                    GAP: begin
                        state     <= SHOW;
                        digit_idx <= idx_inc;
                        shadow    <= shadow_nxt;
                        an        <= an_for(idx_inc);
                        seg       <= seg_for(idx_inc, shadow_nxt);
                    end
                    default: begin
                        state <= IDLE;
                        an    <= '1;
                        seg   <= 7'h7F;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver: a blanking instance and a non-blanking instance share all inputs.
module tb_display_scan_driver;

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic [3:0] value = 4'd0;
    logic       scan_in = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] an, an2;
    logic [6:0] seg, seg2;
    logic [2:0] digit_idx, digit_idx2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    display_scan_driver #(.NUM_DIGITS(4), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .arst(arst), .value(value), .scan_in(scan_in), .enable(enable),
        .an(an), .seg(seg), .digit_idx(digit_idx)
    );

    display_scan_driver #(.NUM_DIGITS(4), .BLANK_LEADING(1'b0)) dut_nb (
        .clk(clk), .arst(arst), .value(value), .scan_in(scan_in), .enable(enable),
        .an(an2), .seg(seg2), .digit_idx(digit_idx2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One scan_in pulse; checks the blanking gap, then the newly shown digit on both instances.
    task automatic scan_pulse(input string tag, input logic [2:0] exp_idx, input logic [3:0] exp_an,
                              input logic [6:0] exp_seg, input logic [6:0] exp_seg2);
        scan_in = 1'b1;
        step(2);
        scan_in = 1'b0;
        step(1);
        check({tag, "_gap_an"}, an, 4'hF);
        step(1);
        check({tag, "_idx"}, digit_idx, exp_idx);
        check({tag, "_an"}, an, exp_an);
        check({tag, "_seg"}, seg, exp_seg);
        check({tag, "_seg_nb"}, seg2, exp_seg2);
        step(2);
    endtask

    initial begin
        step(3);
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_idx", digit_idx, 3'd0);
        check("rst_seg_nb", seg2, 7'h7F);

        enable = 1'b1;
        value  = 4'd0;
        arst   = 1'b1;
        step(1);
        check("start_an", an, 4'b1110);
        check("start_seg", seg, 7'h40);
        check("start_idx", digit_idx, 3'd0);
        check("start_seg_nb", seg2, 7'h40);

        // Shadow is still 0 until the wrap; value=13 appears only after digit 3 -> 0.
        value = 4'd13;
        scan_pulse("p1", 3'd1, 4'b1101, 7'h7F, 7'h40);
        scan_pulse("p2", 3'd2, 4'b1011, 7'h7F, 7'h40);
        scan_pulse("p3", 3'd3, 4'b0111, 7'h7F, 7'h40);
        scan_pulse("p4", 3'd0, 4'b1110, 7'h30, 7'h30);
        value = 4'd5;
        scan_pulse("p5", 3'd1, 4'b1101, 7'h79, 7'h79);
        scan_pulse("p6", 3'd2, 4'b1011, 7'h7F, 7'h40);
        value = 4'd9;
        scan_pulse("p7", 3'd3, 4'b0111, 7'h7F, 7'h40);
        scan_pulse("p8", 3'd0, 4'b1110, 7'h10, 7'h10);
        scan_pulse("p9", 3'd1, 4'b1101, 7'h7F, 7'h40);
        scan_pulse("p10", 3'd2, 4'b1011, 7'h7F, 7'h40);

        enable = 1'b0;
        step(1);
        check("dis_an", an, 4'hF);
        check("dis_seg", seg, 7'h7F);
        check("dis_idx", digit_idx, 3'd2);
        scan_in = 1'b1;
        step(4);
        scan_in = 1'b0;
        step(3);
        check("idle_tick_idx", digit_idx, 3'd2);
        check("idle_tick_an", an, 4'hF);
        enable = 1'b1;
        step(1);
        check("reen_an", an, 4'b1011);
        check("reen_idx", digit_idx, 3'd2);
        check("reen_seg", seg, 7'h7F);
        check("reen_seg_nb", seg2, 7'h40);

        value = 4'd3;
        scan_pulse("q1", 3'd3, 4'b0111, 7'h7F, 7'h40);
        scan_pulse("q2", 3'd0, 4'b1110, 7'h30, 7'h30);
        scan_pulse("q3", 3'd1, 4'b1101, 7'h7F, 7'h40);
        scan_pulse("q4", 3'd2, 4'b1011, 7'h7F, 7'h40);

        // Reset pulsed while in GAP must clear outputs without a clock edge.
        scan_in = 1'b1;
        step(2);
        scan_in = 1'b0;
        step(1);
        check("gap_an", an, 4'hF);
        check("gap_seg", seg, 7'h7F);
        check("gap_seg_nb", seg2, 7'h40);
        #1 arst = 1'b0;
        #1;
        check("arst_an", an, 4'hF);
        check("arst_seg", seg, 7'h7F);
        check("arst_idx", digit_idx, 3'd0);
        check("arst_seg_nb", seg2, 7'h7F);
        check("arst_idx_nb", digit_idx2, 3'd0);
        step(2);
        arst = 1'b1;
        step(1);
        check("rerel_an", an, 4'b1110);
        check("rerel_seg", seg, 7'h40);
        check("rerel_idx", digit_idx, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
